// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with IDLE/ACCESS/RESP FSM.
// Defining DMEM_ARB_RR_EN selects round-robin tie-breaking; the default build uses fixed p0 priority.
module dmem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [31:0]   p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [31:0]   p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic          p1_err,

    output logic [DW-1:0] rdata,

    output logic          mem_rd,
    output logic          mem_wrt,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_datain,
    input  logic [DW-1:0] mem_dataout,

    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_port;
    logic          r_we;
    logic          r_addr_err;
    logic          r_p0_gnt;
    logic          r_p1_gnt;
    logic          r_p0_rvalid;
    logic          r_p1_rvalid;
    logic          r_p0_err;
    logic          r_p1_err;
    logic          r_mem_rd;
    logic          r_mem_wrt;
    logic          r_busy;
    logic [31:0]   r_mem_addr;
    logic [DW-1:0] r_mem_datain;
    logic [DW-1:0] r_rdata;

    logic          w_port_nxt;
    logic          w_we_nxt;
    logic          w_addr_err_nxt;
    logic          w_p0_gnt_nxt;
    logic          w_p1_gnt_nxt;
    logic          w_p0_rvalid_nxt;
    logic          w_p1_rvalid_nxt;
    logic          w_p0_err_nxt;
    logic          w_p1_err_nxt;
    logic          w_mem_rd_nxt;
    logic          w_mem_wrt_nxt;
    logic          w_busy_nxt;
    logic [31:0]   w_mem_addr_nxt;
    logic [DW-1:0] w_mem_datain_nxt;
    logic [DW-1:0] w_rdata_nxt;

    logic          w_any_req;
    logic          w_pick_p1;
    logic          w_sel_we;
    logic          w_sel_err;
    logic [31:0]   w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    assign w_any_req = p0_req | p1_req;

`ifdef DMEM_ARB_RR_EN
    // Remembers whether p1 won the last grant; reset value makes p0 win the first tie.
    logic r_last_p1;

    assign w_pick_p1 = p1_req & (~p0_req | ~r_last_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_p1 <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_p1 <= w_pick_p1;
        end
    end
`else
    assign w_pick_p1 = p1_req & ~p0_req;
`endif

    assign w_sel_we    = w_pick_p1 ? p1_we    : p0_we;
    assign w_sel_addr  = w_pick_p1 ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_pick_p1 ? p1_wdata : p0_wdata;
    assign w_sel_err   = |w_sel_addr[31:AW];

    always_comb begin
        w_state_nxt      = r_state;
        w_port_nxt       = r_port;
        w_we_nxt         = r_we;
        w_addr_err_nxt   = r_addr_err;
        w_p0_gnt_nxt     = 1'b0;
        w_p1_gnt_nxt     = 1'b0;
        w_p0_rvalid_nxt  = 1'b0;
        w_p1_rvalid_nxt  = 1'b0;
        w_p0_err_nxt     = 1'b0;
        w_p1_err_nxt     = 1'b0;
        w_mem_rd_nxt     = 1'b0;
        w_mem_wrt_nxt    = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_datain_nxt = r_mem_datain;
        w_rdata_nxt      = r_rdata;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt      = S_ACCESS;
                    w_port_nxt       = w_pick_p1;
                    w_we_nxt         = w_sel_we;
                    w_addr_err_nxt   = w_sel_err;
                    w_p0_gnt_nxt     = ~w_pick_p1;
                    w_p1_gnt_nxt     = w_pick_p1;
                    // Strobes launch with the grant so memory sees them at the ACCESS negedge.
                    w_mem_rd_nxt     = ~w_sel_we & ~w_sel_err;
                    w_mem_wrt_nxt    = w_sel_we & ~w_sel_err;
                    w_mem_addr_nxt   = {{(32-AW){1'b0}}, w_sel_addr[AW-1:0]};
                    w_mem_datain_nxt = w_sel_wdata;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
                if (r_addr_err) begin
                    w_p0_err_nxt = ~r_port;
                    w_p1_err_nxt = r_port;
                end else begin
                    w_p0_rvalid_nxt = ~r_port;
                    w_p1_rvalid_nxt = r_port;
                    if (!r_we) begin
                        w_rdata_nxt = mem_dataout;
                    end
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_addr_err   <= 1'b0;
            r_p0_gnt     <= 1'b0;
            r_p1_gnt     <= 1'b0;
            r_p0_rvalid  <= 1'b0;
            r_p1_rvalid  <= 1'b0;
            r_p0_err     <= 1'b0;
            r_p1_err     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wrt    <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_datain <= '0;
            r_rdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_port       <= w_port_nxt;
            r_we         <= w_we_nxt;
            r_addr_err   <= w_addr_err_nxt;
            r_p0_gnt     <= w_p0_gnt_nxt;
            r_p1_gnt     <= w_p1_gnt_nxt;
            r_p0_rvalid  <= w_p0_rvalid_nxt;
            r_p1_rvalid  <= w_p1_rvalid_nxt;
            r_p0_err     <= w_p0_err_nxt;
            r_p1_err     <= w_p1_err_nxt;
            r_mem_rd     <= w_mem_rd_nxt;
            r_mem_wrt    <= w_mem_wrt_nxt;
            r_busy       <= w_busy_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_datain <= w_mem_datain_nxt;
            r_rdata      <= w_rdata_nxt;
        end
    end

    assign p0_gnt     = r_p0_gnt;
    assign p1_gnt     = r_p1_gnt;
    assign p0_rvalid  = r_p0_rvalid;
    assign p1_rvalid  = r_p1_rvalid;
    assign p0_err     = r_p0_err;
    assign p1_err     = r_p1_err;
    assign mem_rd     = r_mem_rd;
    assign mem_wrt    = r_mem_wrt;
    assign mem_addr   = r_mem_addr;
    assign mem_datain = r_mem_datain;
    assign rdata      = r_rdata;
    assign busy       = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (transaction model plus directed vectors).
module tb_dmem_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0]   p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0]   p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p0_gnt, p0_rvalid, p0_err;
    logic          p1_gnt, p1_rvalid, p1_err;
    logic [DW-1:0] rdata;
    logic          mem_rd, mem_wrt;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_datain;
    logic [DW-1:0] mem_dataout;
    logic          busy;

    int n_checks = 0;
    int n_errs = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_err(p1_err),
        .rdata(rdata),
        .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_addr(mem_addr),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout),
        .busy(busy)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 2) return 32'd3;
        if (i == 4) return 32'd5;
        if (i == 6) return 32'd20;
        return 32'h100 + 32'(i);
    endfunction

    // Data memory seen by the DUT: samples strobes on negedge, read data valid after it.
    logic [31:0] bmem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = init_val(i);
        mem_dataout = '0;
        forever begin
            @(negedge clk);
            if (mem_wrt) bmem[mem_addr[7:0]] = mem_datain;
            if (mem_rd)  mem_dataout = bmem[mem_addr[7:0]];
        end
    end

    // Transaction-level reference: one in-flight access stamped with its grant cycle.
    logic [31:0] mmem [0:255];
    logic [8:0]  e_ctl;   // {g0,g1,rv0,rv1,er0,er1,rd,wr,busy}
    logic [31:0] e_rdata, e_addr, e_wdata, m_rdata;
    int          k, t_grant, t_port, m_last, w;
    logic        t_valid, t_we, t_ok;
    logic [31:0] t_addr, t_wdata;

    initial begin
        for (int i = 0; i < 256; i++) mmem[i] = init_val(i);
        k = 0; t_valid = 0; t_grant = 0; t_port = 0; m_last = 1; w = 0;
        t_we = 0; t_ok = 0; t_addr = 0; t_wdata = 0;
        m_rdata = 0; e_ctl = 0; e_rdata = 0; e_addr = 0; e_wdata = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = 0; t_valid = 0; m_last = 1; m_rdata = 0;
                e_ctl = 0; e_rdata = 0; e_addr = 0; e_wdata = 0;
            end else begin
                k++;
                e_ctl = 0;
                if (t_valid && k == t_grant + 1) begin
                    if (t_ok) begin
                        if (t_we) mmem[t_addr[7:0]] = t_wdata;
                        else      m_rdata = mmem[t_addr[7:0]];
                    end
                    if (t_port == 0) begin
                        if (t_ok) e_ctl[6] = 1'b1; else e_ctl[4] = 1'b1;
                    end else begin
                        if (t_ok) e_ctl[5] = 1'b1; else e_ctl[3] = 1'b1;
                    end
                    e_ctl[0] = 1'b1;
                end
                if ((!t_valid || k >= t_grant + 3) && (p0_req || p1_req)) begin
                    if (p0_req && p1_req) begin
`ifdef DMEM_ARB_RR_EN
                        w = (m_last == 0) ? 1 : 0;
`else
                        w = 0;
`endif
                    end else begin
                        w = p1_req ? 1 : 0;
                    end
                    m_last  = w;
                    t_valid = 1'b1;
                    t_grant = k;
                    t_port  = w;
                    t_we    = (w == 1) ? p1_we    : p0_we;
                    t_addr  = (w == 1) ? p1_addr  : p0_addr;
                    t_wdata = (w == 1) ? p1_wdata : p0_wdata;
                    t_ok    = ((t_addr >> AW) == 0);
                    e_ctl[8 - w] = 1'b1;
                    e_ctl[2] = t_ok && !t_we;
                    e_ctl[1] = t_ok && t_we;
                    e_ctl[0] = 1'b1;
                    e_addr   = t_addr & 32'h0000_FFFF;
                    e_wdata  = t_wdata;
                end
                e_rdata = m_rdata;
            end
        end
    end

    int cnt_p0_rv = 0;
    int cnt_p1_rv = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (p0_rvalid) cnt_p0_rv++;
            if (p1_rvalid) cnt_p1_rv++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle_checker();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("cyc_ctrl", 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err,
                                     mem_rd, mem_wrt, busy}), 32'(e_ctl));
                chk("cyc_rdata", rdata, e_rdata);
                if (e_ctl[2] || e_ctl[1]) chk("cyc_mem_addr", mem_addr, e_addr);
                if (e_ctl[1]) chk("cyc_mem_datain", mem_datain, e_wdata);
            end
        end
    endtask

    // Called at #1 after a posedge with the DUT idle; returns at #1 after the idle slot that follows.
    task automatic txn(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic v, output logic e, output int lat,
                       output logic mrd, output logic mwr);
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!((port == 0) ? p0_gnt : p1_gnt) && lat < 20);
        mrd = mem_rd;
        mwr = mem_wrt;
        if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
        @(posedge clk); #1;
        v  = (port == 0) ? p0_rvalid : p1_rvalid;
        e  = (port == 0) ? p0_err : p1_err;
        rd = rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rd;
    logic        v, e, mrd, mwr;
    int          lat, ng, nv, cnt0, cnt1;
    logic [5:0]  seq;
    int          rv_cyc [2];
    logic [31:0] rv_dat [2];

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ctrl", 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err,
                             mem_rd, mem_wrt, busy}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_datain", mem_datain, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        fork
            cycle_checker();
        join_none
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single read of word 2, issued as soon as reset is released.
        txn(0, 1'b0, 32'd2, 32'd0, rd, v, e, lat, mrd, mwr);
        chk("rd_lat", 32'(lat), 32'd1);
        chk("rd_mem_rd", 32'(mrd), 32'd1);
        chk("rd_rvalid", 32'(v), 32'd1);
        chk("rd_data", rd, 32'd3);

        // p1 write then read back; p0 must see nothing.
        cnt0 = cnt_p0_rv;
        txn(1, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, v, e, lat, mrd, mwr);
        chk("wr_lat", 32'(lat), 32'd1);
        chk("wr_mem_wrt", 32'(mwr), 32'd1);
        chk("wr_rvalid", 32'(v), 32'd1);
        txn(1, 1'b0, 32'h10, 32'd0, rd, v, e, lat, mrd, mwr);
        chk("wrrd_data", rd, 32'hDEAD_BEEF);
        chk("wrrd_p0_quiet", 32'(cnt_p0_rv - cnt0), 32'd0);

        // Out-of-range address.
        txn(0, 1'b0, 32'h0001_0000, 32'd0, rd, v, e, lat, mrd, mwr);
        chk("aerr_mem_rd", 32'(mrd), 32'd0);
        chk("aerr_err", 32'(e), 32'd1);
        chk("aerr_rvalid", 32'(v), 32'd0);
        chk("aerr_rdata", rd, 32'hDEAD_BEEF);

        // Back-to-back with req held; address change during ACCESS must not disturb the first read.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd6;
        ng = 0; nv = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (p0_gnt) begin
                ng++;
                if (ng == 1) p0_addr = 32'd4; else p0_req = 1'b0;
            end
            if (p0_rvalid) begin
                if (nv < 2) begin rv_cyc[nv] = c; rv_dat[nv] = rdata; end
                nv++;
            end
        end
        p0_req = 1'b0;
        chk("b2b_count", 32'(nv), 32'd2);
        chk("b2b_cyc0", 32'(rv_cyc[0]), 32'd2);
        chk("b2b_cyc1", 32'(rv_cyc[1]), 32'd5);
        chk("b2b_dat0", rv_dat[0], 32'd20);
        chk("b2b_dat1", rv_dat[1], 32'd5);

        // Reset in the middle of a p1 write.
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        chk("abort_gnt", 32'(p1_gnt), 32'd1);
        chk("abort_wrt_before", 32'(mem_wrt), 32'd1);
        cnt1 = cnt_p1_rv;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wrt", 32'(mem_wrt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        p1_req = 1'b0; p1_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_rvalid", 32'(cnt_p1_rv - cnt1), 32'd0);
        rst_n = 1'b1;
        txn(1, 1'b0, 32'h20, 32'd0, rd, v, e, lat, mrd, mwr);
        chk("abort_post_lat", 32'(lat), 32'd1);
        chk("abort_post_data", rd, 32'h120);
        chk("abort_post_rvcnt", 32'(cnt_p1_rv - cnt1), 32'd1);

        // Both ports requesting continuously.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd1;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd3;
        ng = 0; seq = '0;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            if (p0_gnt || p1_gnt) begin
                if (ng < 6) seq[ng] = p1_gnt;
                ng++;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chk("tie_grants", 32'(ng), 32'd6);
`ifdef DMEM_ARB_RR_EN
        chk("tie_sequence", 32'(seq), 32'h2A);
`else
        chk("tie_sequence", 32'(seq), 32'h00);
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: AW, 16, number of low address bits forwarded to data memory; upper address bits must be zero.
REQ-002 Parameter: DW, 32, data width of all data buses.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge.
REQ-004 Port: rst_n  in  1  reset; one clock, asynchronous and active-low.
REQ-005 Port: p0_req, p0_we  in  1 each  CPU port: request valid; 1 = write, 0 = read.
REQ-006 Port: p0_addr, p0_wdata  in  32, DW  CPU port: word address; write data.
REQ-007 Port: p0_gnt, p0_rvalid, p0_err  out  1 each  CPU port: accepted; read data valid or write done; address error.
REQ-008 Port: p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_err  same widths  loader/debug port, identical semantics.
REQ-009 Port: rdata  out  DW  shared read-return bus, meaningful only while pN_rvalid = 1.
REQ-010 Port: mem_rd, mem_wrt  out  1 each  data memory read and write strobes (memory samples them on negedge clk).
REQ-011 Port: mem_addr, mem_datain  out  32, DW  data memory address and write data.
REQ-012 Port: mem_dataout  in  DW  data memory read data, valid after the negedge of the access cycle.
REQ-013 Port: busy  out  1  high whenever state != IDLE.

Function
REQ-014 FSM states: IDLE, ACCESS, RESP; all outputs registered.
REQ-015 IDLE: on posedge with any pN_req = 1, select a winner, pulse pN_gnt for 1 cycle, latch we/addr/wdata and port ID, go to ACCESS.
REQ-016 ACCESS (exactly 1 cycle): mem_rd = !we, mem_wrt = we, mem_addr = {zeros, addr[AW-1:0]}, mem_datain = wdata; then go to RESP, capturing mem_dataout into rdata on reads.
REQ-017 RESP (exactly 1 cycle): pulse the winner's pN_rvalid; strobes low; go to IDLE.
REQ-018 Latency: req sampled at posedge N -> gnt during cycle N+1 -> memory strobes during cycle N+1 -> rvalid and rdata during cycle N+2; next grant no earlier than posedge N+3.
REQ-019 Outside ACCESS, mem_rd = mem_wrt = 0; mem_rd and mem_wrt never both 1.
REQ-020 Address error: if the latched addr[31:AW] != 0, ACCESS issues no strobes and RESP pulses pN_err instead of pN_rvalid; rdata holds its previous value.
REQ-021 Requests are sampled only in IDLE; req changes during ACCESS/RESP have no effect on the access in flight; the losing port keeps req high to retry.
REQ-022 Simultaneous p0_req and p1_req: winner per REQ-027; loser is served at the next IDLE if still requesting.
REQ-023 rdata holds its last captured value until the next successful read.

Reset
REQ-024 On rst_n = 0, immediately and asynchronously: state = IDLE; all gnt/rvalid/err = 0; mem_rd = mem_wrt = 0; mem_addr, mem_datain, rdata = 0; busy = 0; round-robin pointer = port 0 priority.
REQ-025 Reset during ACCESS aborts the access: strobes drop before the next negedge if rst_n falls first; no rvalid for the aborted request.
REQ-026 First grant possible at the first posedge after rst_n rises.

Configuration
REQ-027 Macro DMEM_ARB_RR_EN: defined -> round-robin (the port granted last has lower priority on the next tie; after reset p0 wins the first tie); undefined -> fixed priority, p0 always wins ties.

Verification
REQ-028 Reset: rst_n low mid-ACCESS of a p1 write -> mem_wrt = 0 immediately; no p1_rvalid; busy = 0.
REQ-029 Single read: data memory word 2 = 3; p0 read addr 2 -> p0_gnt at N+1, mem_rd = 1 at N+1, p0_rvalid with rdata = 3 at N+2.
REQ-030 Write then read: p1 writes 0xDEADBEEF to addr 0x10, then p1 reads 0x10 -> rdata = 0xDEADBEEF; p0 sees no rvalid.
REQ-031 Tie: p0 and p1 request continuously -> fixed mode: p0 every grant, p1 starved; RR mode: grants alternate p0, p1, p0, p1.
REQ-032 Address error: p0 read addr 0x0001_0000 -> no mem_rd pulse; p0_err for 1 cycle at N+2; rdata unchanged.
REQ-033 Back-to-back: p0 read addr 6 (value 20), req held high for addr 4 (value 5) -> rvalid at N+2 and N+5 with rdata 20 then 5.
